// File: rtl/arb_mux.sv
// Round-robin N:1 arbitrating mux with a single registered output stage.
// Optional grant locking is compiled in when ARB_MUX_LOCK_EN is defined.
module arb_mux #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned NCH   = 8,
    parameter int unsigned SELW  = 3
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NCH-1:0]         in_valid,
    input  logic [NCH*WIDTH-1:0]   in_data,
`ifdef ARB_MUX_LOCK_EN
    input  logic [NCH-1:0]         in_lock,
`endif
    output logic [NCH-1:0]         in_ready,
    output logic                   out_valid,
    output logic [WIDTH-1:0]       out_data,
    output logic [SELW-1:0]        out_src,
    input  logic                   out_ready
);

    logic [SELW-1:0]  last_grant;
    logic             load_en;
    logic             rr_found;
    logic [SELW-1:0]  rr_idx;
    logic             win_found;
    logic [SELW-1:0]  win_idx;
    logic             grant_en;
    logic             in_xfer;
    logic [WIDTH-1:0] sel_data;
    int unsigned      cand;

    assign load_en = ~out_valid | out_ready;

    // Search starts one past the last grant and wraps at NCH-1.
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = '0;
        cand     = 0;
        for (int unsigned k = 1; k <= NCH; k++) begin
            cand = (32'(last_grant) + k) % NCH;
            if (!rr_found && in_valid[SELW'(cand)]) begin
                rr_found = 1'b1;
                rr_idx   = SELW'(cand);
            end
        end
    end

`ifdef ARB_MUX_LOCK_EN
    logic            lock_active;
    logic [SELW-1:0] lock_owner;

    // A locked owner is the only candidate, even while it is idle.
    always_comb begin
        win_found = rr_found;
        win_idx   = rr_idx;
        if (lock_active) begin
            win_found = in_valid[lock_owner];
            win_idx   = lock_owner;
        end
    end

    // Any owner transfer re-evaluates the lock from its in_lock bit.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            lock_active <= 1'b0;
            lock_owner  <= '0;
        end else if (in_xfer) begin
            lock_active <= in_lock[win_idx];
            lock_owner  <= win_idx;
        end
    end
`else
    always_comb begin
        win_found = rr_found;
        win_idx   = rr_idx;
    end
`endif

    assign grant_en = reset_n & load_en & win_found;
    assign in_xfer  = grant_en;

    always_comb begin
        in_ready = '0;
        if (grant_en) begin
            in_ready[win_idx] = 1'b1;
        end
    end

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < int'(NCH); i++) begin
            if (win_idx == SELW'(i)) begin
                sel_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Output stage: load on input transfer, otherwise drain on output transfer.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_src    <= '0;
            last_grant <= SELW'(NCH - 1);
        end else if (in_xfer) begin
            out_valid  <= 1'b1;
            out_data   <= sel_data;
            out_src    <= win_idx;
            last_grant <= win_idx;
        end else if (out_ready) begin
            out_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_arb_mux.sv
// Directed, table-driven bench for arb_mux (NCH=8, WIDTH=32); lock cases
// run only when ARB_MUX_LOCK_EN is defined.
module tb_arb_mux;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned NCH   = 8;
    localparam int unsigned SELW  = 3;

    typedef struct {
        logic        rst_n;
        logic [7:0]  valid;
        logic        ordy;
        logic [7:0]  exp_ready;
        logic        exp_ov;
        logic [2:0]  exp_src;
        logic [31:0] exp_data;
    } vec_t;

    logic                 clk;
    logic                 reset_n;
    logic [NCH-1:0]       in_valid;
    logic [NCH*WIDTH-1:0] in_data;
    logic [NCH-1:0]       in_ready;
    logic                 out_valid;
    logic [WIDTH-1:0]     out_data;
    logic [SELW-1:0]      out_src;
    logic                 out_ready;
`ifdef ARB_MUX_LOCK_EN
    logic [NCH-1:0]       in_lock;
`endif

    int   n_checks = 0;
    int   n_errors = 0;
    vec_t vecs[$];

    arb_mux #(.WIDTH(WIDTH), .NCH(NCH), .SELW(SELW)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
`ifdef ARB_MUX_LOCK_EN
        .in_lock   (in_lock),
`endif
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] dat(input int unsigned i);
        return 32'hA5C3_0000 ^ (32'h1111_1111 * i);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, check in_ready before the edge and the
    // registered outputs just after it.
    task automatic apply(input string tag, input logic r, input logic [7:0] v, input logic o,
                         input logic [7:0] er, input logic eov, input logic [2:0] es,
                         input logic [31:0] ed);
        reset_n   = r;
        in_valid  = v;
        out_ready = o;
        #1;
        check({tag, ".in_ready"}, 32'(in_ready), 32'(er));
        @(posedge clk);
        #1;
        check({tag, ".out_valid"}, 32'(out_valid), 32'(eov));
        check({tag, ".out_src"}, 32'(out_src), 32'(es));
        check({tag, ".out_data"}, out_data, ed);
    endtask

    initial begin
        reset_n   = 1'b0;
        in_valid  = '0;
        out_ready = 1'b0;
`ifdef ARB_MUX_LOCK_EN
        in_lock   = '0;
`endif
        for (int i = 0; i < int'(NCH); i++) begin
            in_data[i*WIDTH +: WIDTH] = dat(i);
        end

        // Reset with every channel requesting, then fairness sweep 0..7,0.
        vecs.push_back('{1'b0, 8'hFF, 1'b1, 8'h00, 1'b0, 3'd0, 32'h0});
        for (int i = 0; i < 8; i++) begin
            vecs.push_back('{1'b1, 8'hFF, 1'b1, 8'(1 << i), 1'b1, 3'(i), dat(i)});
        end
        vecs.push_back('{1'b1, 8'hFF, 1'b1, 8'h01, 1'b1, 3'd0, dat(0)});
        // Beat from channel 5 held under backpressure, then channel 6 next.
        vecs.push_back('{1'b1, 8'h20, 1'b1, 8'h20, 1'b1, 3'd5, dat(5)});
        for (int i = 0; i < 3; i++) begin
            vecs.push_back('{1'b1, 8'hFF, 1'b0, 8'h00, 1'b1, 3'd5, dat(5)});
        end
        vecs.push_back('{1'b1, 8'hFF, 1'b1, 8'h40, 1'b1, 3'd6, dat(6)});
        // No requests: output drains, data/src hold.
        vecs.push_back('{1'b1, 8'h00, 1'b1, 8'h00, 1'b0, 3'd6, dat(6)});
        vecs.push_back('{1'b1, 8'h00, 1'b1, 8'h00, 1'b0, 3'd6, dat(6)});
        // Sparse wrap with last_grant=6: 7, 1, 7.
        vecs.push_back('{1'b1, 8'h82, 1'b1, 8'h80, 1'b1, 3'd7, dat(7)});
        vecs.push_back('{1'b1, 8'h82, 1'b1, 8'h02, 1'b1, 3'd1, dat(1)});
        vecs.push_back('{1'b1, 8'h82, 1'b1, 8'h80, 1'b1, 3'd7, dat(7)});
        // Single persistent requester granted every cycle.
        for (int i = 0; i < 3; i++) begin
            vecs.push_back('{1'b1, 8'h08, 1'b1, 8'h08, 1'b1, 3'd3, dat(3)});
        end
        vecs.push_back('{1'b1, 8'h08, 1'b0, 8'h00, 1'b1, 3'd3, dat(3)});
        vecs.push_back('{1'b1, 8'h00, 1'b1, 8'h00, 1'b0, 3'd3, dat(3)});
        // Empty output register loads even with out_ready low.
        vecs.push_back('{1'b1, 8'h10, 1'b0, 8'h10, 1'b1, 3'd4, dat(4)});
        // Reset mid-operation drops the held beat and restarts at channel 0.
        vecs.push_back('{1'b0, 8'hFF, 1'b0, 8'h00, 1'b0, 3'd0, 32'h0});
        vecs.push_back('{1'b1, 8'hFF, 1'b1, 8'h01, 1'b1, 3'd0, dat(0)});

        @(posedge clk);
        #1;
        foreach (vecs[i]) begin
            apply($sformatf("vec%0d", i), vecs[i].rst_n, vecs[i].valid, vecs[i].ordy,
                  vecs[i].exp_ready, vecs[i].exp_ov, vecs[i].exp_src, vecs[i].exp_data);
        end

        // Sustained throughput: one beat per cycle continuing from channel 0.
        for (int c = 0; c < 10; c++) begin
            apply($sformatf("thru%0d", c), 1'b1, 8'hFF, 1'b1, 8'(1 << ((c + 1) % 8)),
                  1'b1, 3'((c + 1) % 8), dat((c + 1) % 8));
        end

`ifdef ARB_MUX_LOCK_EN
        apply("lk_rst", 1'b0, 8'hFF, 1'b0, 8'h00, 1'b0, 3'd0, 32'h0);
        in_lock = 8'h04;
        apply("lk_take", 1'b1, 8'h04, 1'b1, 8'h04, 1'b1, 3'd2, dat(2));
        apply("lk_hold0", 1'b1, 8'hFF, 1'b1, 8'h04, 1'b1, 3'd2, dat(2));
        apply("lk_hold1", 1'b1, 8'hFF, 1'b1, 8'h04, 1'b1, 3'd2, dat(2));
        in_lock = 8'h00;
        apply("lk_idle", 1'b1, 8'hFB, 1'b1, 8'h00, 1'b0, 3'd2, dat(2));
        apply("lk_rel", 1'b1, 8'hFF, 1'b1, 8'h04, 1'b1, 3'd2, dat(2));
        apply("lk_next", 1'b1, 8'hFF, 1'b1, 8'h08, 1'b1, 3'd3, dat(3));
        in_lock = 8'h04;
        apply("lk_take2", 1'b1, 8'h04, 1'b1, 8'h04, 1'b1, 3'd2, dat(2));
        in_lock = 8'h00;
        apply("lk_midrst", 1'b0, 8'hFF, 1'b0, 8'h00, 1'b0, 3'd0, 32'h0);
        apply("lk_after", 1'b1, 8'hFF, 1'b1, 8'h01, 1'b1, 3'd0, dat(0));
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
